// File: rtl/fifo_push_ctrl.sv
// Producer-side write controller: buffers an upstream valid/ready stream in a small
// holding queue and pushes it into a flow-controlled FIFO, honouring PAUSE/CONTINUE/fifo_error.
module fifo_push_ctrl #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned HOLD_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic                  PAUSE,
  input  logic                  CONTINUE,
  input  logic                  fifo_error,
  output logic                  push,
  output logic [DATA_WIDTH-1:0] Fifo_Data_in,
  output logic                  paused,
  output logic                  err_out,
  output logic [CNT_WIDTH-1:0]  push_count
);

  localparam int unsigned PtrW = $clog2(HOLD_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(HOLD_DEPTH);

  typedef enum logic [1:0] {StSend, StPaused, StError} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [HOLD_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  accept, do_push;

  // PAUSE is checked before CONTINUE so it wins when both are high.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSend: begin
        if (fifo_error)  state_d = StError;
        else if (PAUSE)  state_d = StPaused;
      end
      StPaused: begin
        if (fifo_error)              state_d = StError;
        else if (CONTINUE && !PAUSE) state_d = StSend;
      end
      default: state_d = StError;
    endcase
  end

  // Readiness uses the registered count, so a full queue refuses even when a pop is due.
  assign ready_out = (count_q < Full) && (state_q != StError) && reset_L;
  assign accept    = valid_in && ready_out;
  assign do_push   = (state_d == StSend) && (count_q != '0);
  assign count_d   = count_q + CntW'(accept) - CntW'(do_push);

  assign paused  = (state_q == StPaused);
  assign err_out = (state_q == StError);

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q      <= StSend;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      push         <= 1'b0;
      Fifo_Data_in <= '0;
      push_count   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      push    <= do_push;
      if (accept) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_push) begin
        Fifo_Data_in <= mem_q[rd_ptr_q];
        rd_ptr_q     <= rd_ptr_q + PtrW'(1);
        push_count   <= push_count + CNT_WIDTH'(1);
      end
    end
  end

  // Storage needs no reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_fifo_push_ctrl.sv
// Bench for fifo_push_ctrl: queue-based behavioural model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fifo_push_ctrl;

  logic       clk = 1'b0;
  logic       reset_L, valid_in, ready_out, PAUSE, CONTINUE, fifo_error;
  logic       push, paused, err_out;
  logic [5:0] data_in, Fifo_Data_in;
  logic [7:0] push_count;

  fifo_push_ctrl #(.DATA_WIDTH(6), .HOLD_DEPTH(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .PAUSE(PAUSE), .CONTINUE(CONTINUE), .fifo_error(fifo_error),
    .push(push), .Fifo_Data_in(Fifo_Data_in), .paused(paused), .err_out(err_out),
    .push_count(push_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a plain queue plus pause/error flags, updated at every rising edge.
  logic [5:0] m_q[$];
  bit         m_paused, m_err, m_push, mdl_ok;
  logic [5:0] m_data;
  logic [7:0] m_cnt;

  always @(posedge clk) begin
    bit acc;
    if (!reset_L) begin
      m_q.delete();
      m_paused = 0; m_err = 0; m_push = 0; m_data = '0; m_cnt = '0; mdl_ok = 1;
    end else if (mdl_ok) begin
      acc = valid_in && (m_q.size() < 4) && !m_err;
      if (m_err || fifo_error) begin
        m_err = 1; m_paused = 0;
      end else if (PAUSE) m_paused = 1;
      else if (CONTINUE) m_paused = 0;
      m_push = !m_err && !m_paused && (m_q.size() != 0);
      if (m_push) begin
        m_data = m_q.pop_front();
        m_cnt  = m_cnt + 8'd1;
      end
      if (acc) m_q.push_back(data_in);
    end
  end

  logic [5:0] cap[$];

  always @(negedge clk) begin
    if (mdl_ok) begin
      chk("push", push, m_push);
      chk("data", Fifo_Data_in, m_data);
      chk("paused", paused, m_paused);
      chk("err_out", err_out, m_err);
      chk("push_count", push_count, m_cnt);
      chk("ready_out", ready_out, reset_L && (m_q.size() < 4) && !m_err);
      if (push === 1'b1) cap.push_back(Fifo_Data_in);
    end
  end

  // Upstream source: offers src[0] and holds it until the handshake completes.
  logic [5:0] src[$];

  task automatic cycle();
    bit hs;
    valid_in = (src.size() != 0);
    data_in  = valid_in ? src[0] : 6'd0;
    @(negedge clk);
    hs = valid_in && ready_out;
    @(posedge clk);
    #2;
    if (hs) void'(src.pop_front());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] exp_s[5];
    int bad;
    exp_s = '{6'h01, 6'h16, 6'h30, 6'h1C, 6'h1D};
    reset_L = 0; valid_in = 0; data_in = 0; PAUSE = 0; CONTINUE = 0; fifo_error = 0;
    run(2);
    chk("rst_push", push, 0);
    chk("rst_count", push_count, 0);
    chk("rst_data", Fifo_Data_in, 0);
    reset_L = 1;

    // Stream of five words
    cap.delete();
    foreach (exp_s[i]) src.push_back(exp_s[i]);
    cycle();
    chk("first_accept_no_push", push, 0);
    cycle();
    chk("first_push", push, 1);
    chk("first_data", Fifo_Data_in, 6'h01);
    run(6);
    chk("stream_count", push_count, 5);
    chk("stream_len", cap.size(), 5);
    bad = 0;
    foreach (exp_s[i]) if (cap.size() > i && cap[i] != exp_s[i]) bad++;
    chk("stream_order", bad, 0);

    // Pause hysteresis
    src = '{6'h21, 6'h22, 6'h23, 6'h24};
    run(3);
    PAUSE = 1;
    cycle();
    chk("pause_push", push, 0);
    chk("pause_flag", paused, 1);
    PAUSE = 0;
    run(2);
    chk("hold_push", push, 0);
    chk("hold_flag", paused, 1);
    CONTINUE = 1;
    cycle();
    chk("resume_push", push, 1);
    chk("resume_data", Fifo_Data_in, 6'h23);
    chk("resume_flag", paused, 0);
    CONTINUE = 0;
    cycle();
    chk("resume_data2", Fifo_Data_in, 6'h24);
    chk("pause_count", push_count, 9);

    // Backpressure while paused
    PAUSE = 1;
    cycle();
    src = '{6'h31, 6'h32, 6'h33, 6'h34, 6'h35, 6'h36};
    run(4);
    chk("bp_left", src.size(), 2);
    chk("bp_ready", ready_out, 0);
    run(2);
    chk("bp_still_left", src.size(), 2);
    PAUSE = 0; CONTINUE = 1;
    cycle();
    CONTINUE = 0;
    run(8);
    chk("bp_count", push_count, 15);
    chk("bp_drained", src.size(), 0);

    // PAUSE and CONTINUE together
    PAUSE = 1; CONTINUE = 1;
    src = '{6'h3A, 6'h3B};
    run(3);
    chk("both_push", push, 0);
    chk("both_paused", paused, 1);
    PAUSE = 0;
    cycle();
    CONTINUE = 0;
    run(3);
    chk("both_count", push_count, 17);

    // Sticky error, then reset
    PAUSE = 1;
    src = '{6'h05, 6'h06, 6'h07};
    run(3);
    fifo_error = 1;
    cycle();
    fifo_error = 0; PAUSE = 0;
    src.push_back(6'h08);
    run(3);
    chk("err_flag", err_out, 1);
    chk("err_push", push, 0);
    chk("err_ready", ready_out, 0);
    chk("err_count", push_count, 17);
    chk("err_upstream_held", src.size(), 1);
    reset_L = 0;
    src.delete();
    cycle();
    reset_L = 1;
    chk("clr_err", err_out, 0);
    chk("clr_count", push_count, 0);
    chk("clr_data", Fifo_Data_in, 0);
    chk("clr_push", push, 0);
    run(2);

    // 257 pushes to wrap the counter
    cap.delete();
    for (int i = 0; i < 257; i++) src.push_back(6'(i));
    for (int i = 0; i < 400 && src.size() != 0; i++) cycle();
    chk("wrap_drained", src.size(), 0);
    run(3);
    chk("wrap_count", push_count, 1);
    chk("wrap_len", cap.size(), 257);
    bad = 0;
    foreach (cap[i]) if (cap[i] != 6'(i)) bad++;
    chk("wrap_order", bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
